// File: rtl/spi_master_interface.sv
// rtl/spi_master_interface.sv - SPI master turning host commands into SS_n/MOSI frames with MISO read capture
// Shares clk with the slave: one MOSI bit per clk, all outputs registered.
module spi_master_interface #(
    parameter int RD_LATENCY = 3,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       a_rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [7:0] cmd_data,
    input  logic       MISO,
    output logic       SS_n,
    output logic       MOSI,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        WAIT,
        CAPTURE,
        GAP
    } state_t;

    localparam logic [3:0] SHIFT_LAST = 4'd10;
    localparam logic [3:0] WAIT_LAST  = 4'(RD_LATENCY - 2);
    localparam logic [3:0] CAP_LAST   = 4'd7;
    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [9:0] word, word_nxt;
    logic       rd_cmd, rd_cmd_nxt;
    logic [7:0] cap, cap_nxt;
    logic [7:0] rd_data_nxt;
    logic       ss_n_nxt, mosi_nxt, rd_valid_nxt, busy_nxt;
    logic       accept;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // Outputs are computed for the coming cycle and registered with the state.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        word_nxt     = word;
        rd_cmd_nxt   = rd_cmd;
        cap_nxt      = cap;
        rd_data_nxt  = rd_data;
        ss_n_nxt     = SS_n;
        mosi_nxt     = 1'b0;
        rd_valid_nxt = 1'b0;
        busy_nxt     = busy;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt  = LEAD;
                    cnt_nxt    = 4'd0;
                    word_nxt   = {cmd_type, cmd_data};
                    rd_cmd_nxt = (cmd_type == 2'b11);
                    ss_n_nxt   = 1'b0;
                    busy_nxt   = 1'b1;
                end
            end
            LEAD: begin
                state_nxt = SHIFT;
                cnt_nxt   = 4'd0;
                mosi_nxt  = word[9];
            end
            SHIFT: begin
                // First SHIFT cycle repeats the command-select bit; word shifts from then on.
                if (cnt == SHIFT_LAST) begin
                    cnt_nxt = 4'd0;
                    if (!rd_cmd) begin
                        state_nxt = GAP;
                        ss_n_nxt  = 1'b1;
                    end else if (RD_LATENCY == 1) begin
                        state_nxt = CAPTURE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end else begin
                    cnt_nxt  = cnt + 4'd1;
                    mosi_nxt = word[9];
                    word_nxt = {word[8:0], 1'b0};
                end
            end
            WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_nxt = CAPTURE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            CAPTURE: begin
                cap_nxt = {MISO, cap[7:1]};
                if (cnt == CAP_LAST) begin
                    state_nxt    = GAP;
                    cnt_nxt      = 4'd0;
                    ss_n_nxt     = 1'b1;
                    rd_valid_nxt = 1'b1;
                    rd_data_nxt  = {MISO, cap[7:1]};
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                    busy_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = GAP;
                cnt_nxt   = 4'd0;
                ss_n_nxt  = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state    <= GAP;
            cnt      <= 4'd0;
            word     <= 10'd0;
            rd_cmd   <= 1'b0;
            cap      <= 8'd0;
            rd_data  <= 8'd0;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            word     <= word_nxt;
            rd_cmd   <= rd_cmd_nxt;
            cap      <= cap_nxt;
            rd_data  <= rd_data_nxt;
            SS_n     <= ss_n_nxt;
            MOSI     <= mosi_nxt;
            rd_valid <= rd_valid_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_spi_master_interface.sv
// tb/tb_spi_master_interface.sv - directed bench for spi_master_interface with a slave+RAM model
// DUT 0 uses RD_LATENCY=3, DUT 1 RD_LATENCY=1, DUT 2 RD_LATENCY=5; all GAP_CYCLES=2.
module tb_spi_master_interface;

    logic       clk;
    logic       a_rst;
    logic [2:0] cmd_valid;
    logic [2:0] cmd_ready;
    logic [1:0] cmd_type [3];
    logic [7:0] cmd_data [3];
    logic [2:0] miso;
    logic [2:0] ss_n;
    logic [2:0] mosi;
    logic [7:0] rd_data [3];
    logic [2:0] rd_valid;
    logic [2:0] busy;

    int n_assert = 0;
    int n_fail   = 0;

    spi_master_interface #(.RD_LATENCY(3), .GAP_CYCLES(2)) u_dut0 (
        .clk(clk), .a_rst(a_rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_type(cmd_type[0]), .cmd_data(cmd_data[0]), .MISO(miso[0]), .SS_n(ss_n[0]),
        .MOSI(mosi[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .busy(busy[0])
    );
    spi_master_interface #(.RD_LATENCY(1), .GAP_CYCLES(2)) u_dut1 (
        .clk(clk), .a_rst(a_rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_type(cmd_type[1]), .cmd_data(cmd_data[1]), .MISO(miso[1]), .SS_n(ss_n[1]),
        .MOSI(mosi[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .busy(busy[1])
    );
    spi_master_interface #(.RD_LATENCY(5), .GAP_CYCLES(2)) u_dut2 (
        .clk(clk), .a_rst(a_rst), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
        .cmd_type(cmd_type[2]), .cmd_data(cmd_data[2]), .MISO(miso[2]), .SS_n(ss_n[2]),
        .MOSI(mosi[2]), .rd_data(rd_data[2]), .rd_valid(rd_valid[2]), .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rl_of(input int i);
        case (i)
            0:       return 3;
            1:       return 1;
            default: return 5;
        endcase
    endfunction

    // Slave + RAM model: frame cycles 2..11 carry the 10-bit word, reply bit k in cycle 11+RL+k.
    logic [7:0] ram     [3][256];
    int         fcyc    [3];
    logic [9:0] sh      [3];
    logic [7:0] addr_r  [3];
    logic [7:0] raddr_r [3];
    logic [7:0] reply   [3];
    logic       reading [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ss_n[i] !== 1'b0) begin
                fcyc[i]    = 0;
                reading[i] = 1'b0;
                miso[i]    = 1'b0;
            end else begin
                if (fcyc[i] >= 2 && fcyc[i] <= 11) sh[i] = {sh[i][8:0], mosi[i]};
                if (fcyc[i] == 11) begin
                    case (sh[i][9:8])
                        2'b00: addr_r[i] = sh[i][7:0];
                        2'b01: ram[i][addr_r[i]] = sh[i][7:0];
                        2'b10: raddr_r[i] = sh[i][7:0];
                        default: begin
                            reply[i]   = ram[i][raddr_r[i]];
                            reading[i] = 1'b1;
                        end
                    endcase
                end
                if (reading[i] && fcyc[i] >= 11 + rl_of(i) && fcyc[i] <= 18 + rl_of(i))
                    miso[i] = reply[i][fcyc[i] - 11 - rl_of(i)];
                else
                    miso[i] = 1'b0;
                fcyc[i] = fcyc[i] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int i);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (cmd_ready[i] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ready_timeout", 32'(ok), 32'd1);
    endtask

    task automatic do_cmd(input int i, input logic [1:0] t, input logic [7:0] d,
                          output int low, output logic [10:0] mseq, output int rv_n,
                          output logic [7:0] rv_d, output int rv_c, output int rise,
                          output logic busy0);
        bit ok;
        low = 0; mseq = '0; rv_n = 0; rv_d = '0; rv_c = -1; rise = -1; busy0 = 1'b0;
        wait_ready(i);
        cmd_type[i]  = t;
        cmd_data[i]  = d;
        cmd_valid[i] = 1'b1;
        @(posedge clk);
        #1 cmd_valid[i] = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c == 0) busy0 = busy[i];
            if (ss_n[i] === 1'b0) begin
                low++;
                if (c >= 1 && c <= 11) mseq = {mseq[9:0], mosi[i]};
            end else if (rise < 0) begin
                rise = c;
            end
            if (rd_valid[i] === 1'b1) begin
                rv_n++;
                rv_d = rd_data[i];
                rv_c = c;
            end
            if (cmd_ready[i] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("frame_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          low, rv_n, rv_c, rise, viol, fall2, rdy_c, rv;
        logic [10:0] mseq;
        logic [7:0]  rv_d;
        logic        busy0;

        a_rst = 1'b1;
        cmd_valid = '0;
        for (int i = 0; i < 3; i++) begin
            cmd_type[i] = '0; cmd_data[i] = '0; fcyc[i] = 0; sh[i] = '0;
            addr_r[i] = '0; raddr_r[i] = '0; reply[i] = '0; reading[i] = 1'b0;
        end
        miso = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ss_n", 32'(ss_n[0]), 32'd1);
        chk("rst_mosi", 32'(mosi[0]), 32'd0);
        chk("rst_rd_data", 32'(rd_data[0]), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready[0]), 32'd0);
        a_rst = 1'b0;
        @(negedge clk);
        chk("ready_gap1", 32'(cmd_ready[0]), 32'd0);
        @(negedge clk);
        chk("ready_gap2", 32'(cmd_ready[0]), 32'd1);

        // Write address 0x5A
        do_cmd(0, 2'b00, 8'h5A, low, mseq, rv_n, rv_d, rv_c, rise, busy0);
        chk("wa_low", 32'(low), 32'd12);
        chk("wa_mosi_seq", 32'(mseq), 32'h05A);
        chk("wa_rd_valid", 32'(rv_n), 32'd0);
        chk("wa_rise", 32'(rise), 32'd12);
        chk("wa_busy", 32'(busy0), 32'd1);
        chk("wa_model_addr", 32'(addr_r[0]), 32'h5A);

        // Write 0xC3 to address 0x10
        do_cmd(0, 2'b00, 8'h10, low, mseq, rv_n, rv_d, rv_c, rise, busy0);
        do_cmd(0, 2'b01, 8'hC3, low, mseq, rv_n, rv_d, rv_c, rise, busy0);
        chk("wd_low", 32'(low), 32'd12);
        chk("wd_mosi_seq", 32'(mseq), 32'h1C3);
        chk("wd_ram", 32'(ram[0][8'h10]), 32'hC3);

        // Read address then read data
        do_cmd(0, 2'b10, 8'h10, low, mseq, rv_n, rv_d, rv_c, rise, busy0);
        chk("ra_low", 32'(low), 32'd12);
        chk("ra_rd_valid", 32'(rv_n), 32'd0);
        do_cmd(0, 2'b11, 8'h00, low, mseq, rv_n, rv_d, rv_c, rise, busy0);
        chk("rd_low", 32'(low), 32'd22);
        chk("rd_mosi_seq", 32'(mseq), 32'h700);
        chk("rd_valid_count", 32'(rv_n), 32'd1);
        chk("rd_data", 32'(rv_d), 32'hC3);
        chk("rd_valid_cycle", 32'(rv_c), 32'd22);
        chk("rd_rise", 32'(rise), 32'd22);
        chk("rd_data_hold", 32'(rd_data[0]), 32'hC3);

        // Back-pressure: cmd_valid stays high across a frame
        wait_ready(0);
        cmd_type[0] = 2'b00; cmd_data[0] = 8'h33; cmd_valid[0] = 1'b1;
        @(posedge clk);
        #1 cmd_data[0] = 8'h44;
        viol = 0; rise = -1; fall2 = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c < 14 && cmd_ready[0] === 1'b1) viol++;
            if (rise < 0 && ss_n[0] === 1'b1) rise = c;
            if (rise >= 0 && ss_n[0] === 1'b0) begin
                fall2 = c;
                cmd_valid[0] = 1'b0;
                break;
            end
        end
        cmd_valid[0] = 1'b0;
        chk("bp_ready_low", 32'(viol), 32'd0);
        chk("bp_rise", 32'(rise), 32'd12);
        chk("bp_next_frame", 32'(fall2), 32'd15);
        wait_ready(0);
        chk("bp_second_addr", 32'(addr_r[0]), 32'h44);
        chk("bp_rd_data_hold", 32'(rd_data[0]), 32'hC3);

        // Mid-frame reset during a read-data frame
        wait_ready(0);
        cmd_type[0] = 2'b11; cmd_data[0] = 8'hFF; cmd_valid[0] = 1'b1;
        @(posedge clk);
        #1 cmd_valid[0] = 1'b0;
        repeat (7) @(negedge clk);
        chk("mr_frame_active", 32'(ss_n[0]), 32'd0);
        chk("mr_mosi_before", 32'(mosi[0]), 32'd1);
        a_rst = 1'b1;
        #1;
        chk("mr_ss_n", 32'(ss_n[0]), 32'd1);
        chk("mr_mosi", 32'(mosi[0]), 32'd0);
        chk("mr_busy", 32'(busy[0]), 32'd0);
        chk("mr_cmd_ready", 32'(cmd_ready[0]), 32'd0);
        chk("mr_rd_data", 32'(rd_data[0]), 32'd0);
        repeat (2) @(negedge clk);
        a_rst = 1'b0;
        rv = 0; rdy_c = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (rd_valid[0] === 1'b1) rv++;
            if (rdy_c < 0 && cmd_ready[0] === 1'b1) rdy_c = c;
        end
        chk("mr_no_rd_valid", 32'(rv), 32'd0);
        chk("mr_ready_delay", 32'(rdy_c), 32'd2);

        // RD_LATENCY sweep on DUT 1 (RL=1) and DUT 2 (RL=5)
        for (int i = 1; i <= 2; i++) begin
            do_cmd(i, 2'b00, 8'h20, low, mseq, rv_n, rv_d, rv_c, rise, busy0);
            do_cmd(i, 2'b01, 8'hA5, low, mseq, rv_n, rv_d, rv_c, rise, busy0);
            do_cmd(i, 2'b10, 8'h20, low, mseq, rv_n, rv_d, rv_c, rise, busy0);
            do_cmd(i, 2'b11, 8'h00, low, mseq, rv_n, rv_d, rv_c, rise, busy0);
            chk("sw_rd_data", 32'(rv_d), 32'hA5);
            chk("sw_rd_valid_count", 32'(rv_n), 32'd1);
            chk("sw_low", 32'(low), 32'(19 + rl_of(i)));
            chk("sw_rd_valid_cycle", 32'(rv_c), 32'(19 + rl_of(i)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
